iiitb_sd_fsm_multi: RTL and testbench

//  Parametrised successor to the single-channel sequence-detector FSM.

---
 rtl/iiitb_sd_fsm_multi.sv | 177 +++++++++++++++++
 tb/tb_iiitb_sd_fsm_multi.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_sd_fsm_multi.sv
// ---------------------------------------------------------------------------
// iiitb_sd_fsm_multi
//
// Multi-channel bit-serial sequence detector. CHANNELS independent detectors
// compare their own serial stream against one shared, runtime-programmable
// pattern of 1..MAX_LEN bits. Each channel supports overlapping or
// non-overlapping detection and keeps a saturating match counter.
//
// Ports
//   clock         system clock, rising edge
//   reset         asynchronous, active-high; clears all state
//   enable        1 = detectors run; 0 = histories held, no matches
//   cfg_we        write strobe for cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern   pattern; bit [L-1] is received first, bit 0 last
//   cfg_len       pattern length L, legal range 1..MAX_LEN
//   cfg_overlap   1 = overlapping detection, 0 = non-overlapping
//   in_valid      qualifies sequence_in for all channels
//   sequence_in   one serial data bit per channel
//   count_clr     synchronous clear of all match counters
//   detector_out  one-cycle registered match pulse per channel
//   match_count   saturating counters, channel c at [c*CNT_W +: CNT_W]
//   cfg_err       sticky flag: a write with an illegal length was rejected
// ---------------------------------------------------------------------------
module iiitb_sd_fsm_multi #(
    parameter  int CHANNELS = 4,
    parameter  int MAX_LEN  = 8,
    parameter  int CNT_W    = 8,
    localparam int LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      cfg_we,
    input  logic [MAX_LEN-1:0]        cfg_pattern,
    input  logic [LEN_W-1:0]          cfg_len,
    input  logic                      cfg_overlap,
    input  logic                      in_valid,
    input  logic [CHANNELS-1:0]       sequence_in,
    input  logic                      count_clr,
    output logic [CHANNELS-1:0]       detector_out,
    output logic [CHANNELS*CNT_W-1:0] match_count,
    output logic                      cfg_err
);

    // Per-channel detector state is carried by the fill counter; the enum
    // names the three regions of that counter relative to the pattern length.
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILLING,
        ST_ARMED
    } state_t;

    localparam logic [LEN_W-1:0] FULL    = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Low-L-bit mask; computed one bit wider so L == MAX_LEN does not overflow.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [MAX_LEN:0] m;
        m = ({{MAX_LEN{1'b0}}, 1'b1} << len) - 1'b1;
        return m[MAX_LEN-1:0];
    endfunction

    function automatic state_t classify(input logic [LEN_W-1:0] fill,
                                        input logic [LEN_W-1:0] len);
        state_t s;
        if (fill == '0)
            s = ST_EMPTY;
        else if (fill < len)
            s = ST_FILLING;
        else
            s = ST_ARMED;
        return s;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Latched configuration
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;

    // Per-channel state
    logic [MAX_LEN-1:0] hist_q   [CHANNELS];
    logic [LEN_W-1:0]   fill_q   [CHANNELS];
    logic [CNT_W-1:0]   cnt_q    [CHANNELS];

    // Next-state terms
    logic [MAX_LEN-1:0] hist_sh    [CHANNELS];
    logic [LEN_W-1:0]   fill_inc   [CHANNELS];
    state_t             state_post [CHANNELS];
    logic [MAX_LEN-1:0] hist_d     [CHANNELS];
    logic [LEN_W-1:0]   fill_d     [CHANNELS];
    logic [CNT_W-1:0]   cnt_d      [CHANNELS];
    logic [CHANNELS-1:0] match_d;

    logic               accept;
    logic               cfg_legal;
    logic               cfg_load;
    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] pat_masked;

    // A config write steals the cycle: the input bit is discarded even when
    // the write itself is rejected.
    assign accept    = enable & in_valid & ~cfg_we;
    assign cfg_legal = (cfg_len != '0) && (cfg_len <= FULL);
    assign cfg_load  = cfg_we & cfg_legal;

    always_comb begin
        mask       = len_mask(len_q);
        pat_masked = pat_q & mask;
        match_d    = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            hist_sh[c]    = {hist_q[c][MAX_LEN-2:0], sequence_in[c]};
            fill_inc[c]   = (fill_q[c] == FULL) ? FULL : fill_q[c] + 1'b1;
            state_post[c] = classify(fill_inc[c], len_q);

            // Match is judged on the post-shift history and post-shift fill,
            // so a pulse is possible on the very bit that arms the channel.
            match_d[c] = accept && (state_post[c] == ST_ARMED) &&
                         ((hist_sh[c] & mask) == pat_masked);

            hist_d[c] = accept ? hist_sh[c] : hist_q[c];

            // History is kept across a legal config write; clearing fill is
            // enough to mask the stale bits.
            fill_d[c] = fill_q[c];
            if (cfg_load)
                fill_d[c] = '0;
            else if (accept)
                fill_d[c] = (match_d[c] && !ovl_q) ? '0 : fill_inc[c];

            // Clear wins over increment, but a coincident match still counts.
            if (count_clr)
                cnt_d[c] = CNT_W'(match_d[c]);
            else if (match_d[c])
                cnt_d[c] = sat_inc(cnt_q[c]);
            else
                cnt_d[c] = cnt_q[c];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pat_q        <= '0;
            len_q        <= FULL;
            ovl_q        <= 1'b1;
            cfg_err      <= 1'b0;
            detector_out <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                hist_q[c] <= '0;
                fill_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
        end else begin
            if (cfg_load) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_len;
                ovl_q <= cfg_overlap;
            end
            if (cfg_we && !cfg_legal)
                cfg_err <= 1'b1;
            detector_out <= match_d;
            for (int c = 0; c < CHANNELS; c++) begin
                hist_q[c] <= hist_d[c];
                fill_q[c] <= fill_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_cnt_out
        assign match_count[c*CNT_W +: CNT_W] = cnt_q[c];
    end

endmodule

// File: tb/tb_iiitb_sd_fsm_multi.sv
// ---------------------------------------------------------------------------
// tb_iiitb_sd_fsm_multi
//
// Self-checking bench for iiitb_sd_fsm_multi. A behavioural model keeps, per
// channel, the list of bits received since the channel was last cleared and
// decides a match by comparing the newest L bits against the pattern. Every
// cycle the DUT outputs are compared with the model; directed scenarios add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_iiitb_sd_fsm_multi;

    localparam int CH      = 4;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                   clock;
    logic                   reset;
    logic                   enable;
    logic                   cfg_we;
    logic [MAX_LEN-1:0]     cfg_pattern;
    logic [LEN_W-1:0]       cfg_len;
    logic                   cfg_overlap;
    logic                   in_valid;
    logic [CH-1:0]          sequence_in;
    logic                   count_clr;
    logic [CH-1:0]          detector_out;
    logic [CH*CNT_W-1:0]    match_count;
    logic                   cfg_err;

    iiitb_sd_fsm_multi #(
        .CHANNELS (CH),
        .MAX_LEN  (MAX_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .cfg_we       (cfg_we),
        .cfg_pattern  (cfg_pattern),
        .cfg_len      (cfg_len),
        .cfg_overlap  (cfg_overlap),
        .in_valid     (in_valid),
        .sequence_in  (sequence_in),
        .count_clr    (count_clr),
        .detector_out (detector_out),
        .match_count  (match_count),
        .cfg_err      (cfg_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [MAX_LEN-1:0] m_pat;
    int                 m_len;
    bit                 m_ovl;
    bit                 m_err;
    bit                 seen [CH][$];
    logic [CH-1:0]      exp_det;
    int                 exp_cnt [CH];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_pat   = '0;
        m_len   = MAX_LEN;
        m_ovl   = 1'b1;
        m_err   = 1'b0;
        exp_det = '0;
        for (int c = 0; c < CH; c++) begin
            seen[c].delete();
            exp_cnt[c] = 0;
        end
    endtask

    // One clock edge of the reference behaviour, from the inputs as the DUT
    // sampled them.
    task automatic model_tick();
        bit hit [CH];
        if (reset) begin
            model_clear();
            return;
        end
        for (int c = 0; c < CH; c++) hit[c] = 1'b0;
        if (cfg_we) begin
            if (cfg_len >= 1 && int'(cfg_len) <= MAX_LEN) begin
                m_pat = cfg_pattern;
                m_len = int'(cfg_len);
                m_ovl = cfg_overlap;
                for (int c = 0; c < CH; c++) seen[c].delete();
            end else begin
                m_err = 1'b1;
            end
        end else if (enable && in_valid) begin
            for (int c = 0; c < CH; c++) begin
                seen[c].push_back(sequence_in[c]);
                if (seen[c].size() > MAX_LEN) seen[c].delete(0);
                if (seen[c].size() >= m_len) begin
                    hit[c] = 1'b1;
                    // newest bit pairs with pattern bit 0
                    for (int k = 0; k < m_len; k++)
                        if (seen[c][seen[c].size() - 1 - k] != m_pat[k]) hit[c] = 1'b0;
                end
                if (hit[c] && !m_ovl) seen[c].delete();
            end
        end
        for (int c = 0; c < CH; c++) begin
            exp_det[c] = hit[c];
            if (count_clr)
                exp_cnt[c] = hit[c] ? 1 : 0;
            else if (hit[c] && exp_cnt[c] < CNT_MAX)
                exp_cnt[c]++;
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < CH; c++) begin
            check($sformatf("det[%0d]", c), int'(detector_out[c]), int'(exp_det[c]));
            check($sformatf("cnt[%0d]", c), int'(match_count[c*CNT_W +: CNT_W]), exp_cnt[c]);
        end
        check("cfg_err", int'(cfg_err), int'(m_err));
    endtask

    task automatic step();
        @(posedge clock);
        model_tick();
        @(negedge clock);
        compare_all();
    endtask

    task automatic feed(input logic b0, output logic det0);
        in_valid       = 1'b1;
        sequence_in    = CH'($urandom);
        sequence_in[0] = b0;
        step();
        det0     = detector_out[0];
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [MAX_LEN-1:0] pat, input int len, input logic ovl);
        cfg_we      = 1'b1;
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        in_valid    = 1'b1;
        sequence_in = CH'($urandom);
        step();
        cfg_we   = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        count_clr = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    logic [7:0] p;
    logic [6:0] s7;

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        cfg_we      = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        cfg_overlap = 1'b0;
        in_valid    = 1'b0;
        sequence_in = '0;
        count_clr   = 1'b0;
        p           = '0;
        s7          = 7'b1011011;
        model_clear();

        step();
        step();
        check("reset_det", int'(detector_out), 0);
        check("reset_cnt", int'(match_count), 0);
        check("reset_err", int'(cfg_err), 0);
        reset  = 1'b0;
        enable = 1'b1;
        idle(1);

        // Overlapping 1011 on stream 1011011: pulses after bits 4 and 7
        cfg_write(8'b0000_1011, 4, 1'b1);
        p = '0;
        for (int i = 0; i < 7; i++) feed(s7[6-i], p[i]);
        check("ovl_pulses", int'(p[6:0]), int'(7'b1001000));
        check("ovl_count", int'(match_count[7:0]), 2);

        // Same stream, non-overlapping: single pulse after bit 4
        count_clr = 1'b1;
        step();
        count_clr = 1'b0;
        cfg_write(8'b0000_1011, 4, 1'b0);
        p = '0;
        for (int i = 0; i < 7; i++) feed(s7[6-i], p[i]);
        check("novl_pulses", int'(p[6:0]), int'(7'b0001000));
        check("novl_count", int'(match_count[7:0]), 1);

        // Illegal lengths rejected, old pattern still detected
        cfg_write(8'hFF, 0, 1'b1);
        cfg_write(8'hFF, MAX_LEN + 1, 1'b1);
        check("err_sticky", int'(cfg_err), 1);
        p = '0;
        feed(1'b1, p[0]);
        feed(1'b0, p[1]);
        feed(1'b1, p[2]);
        feed(1'b1, p[3]);
        check("err_old_pattern", int'(p[3:0]), int'(4'b1000));

        // Mid-stream write of 110/L=3: stale history must not complete a match
        feed(1'b0, p[0]);
        feed(1'b1, p[0]);
        cfg_write(8'b0000_0110, 3, 1'b1);
        p = '0;
        feed(1'b1, p[0]);
        feed(1'b0, p[1]);
        feed(1'b1, p[2]);
        feed(1'b1, p[3]);
        feed(1'b0, p[4]);
        check("refill_pulses", int'(p[4:0]), int'(5'b10000));

        // Counter saturation with L=1 pattern 1
        cfg_write(8'h01, 1, 1'b1);
        for (int i = 0; i < 260; i++) feed(1'b1, p[0]);
        check("cnt_saturated", int'(match_count[7:0]), CNT_MAX);
        count_clr = 1'b1;
        feed(1'b1, p[0]);
        count_clr = 1'b0;
        check("clr_with_match", int'(match_count[7:0]), 1);

        // L=1 non-overlap: every bit equal to pattern[0] matches
        cfg_write(8'h00, 1, 1'b0);
        p = '0;
        feed(1'b0, p[0]);
        feed(1'b0, p[1]);
        feed(1'b1, p[2]);
        feed(1'b0, p[3]);
        check("len1_pulses", int'(p[3:0]), int'(4'b1011));

        // Build count=5, fill=3, then reset asynchronously mid-cycle
        count_clr = 1'b1;
        step();
        count_clr = 1'b0;
        cfg_write(8'h00, 4, 1'b1);
        for (int i = 0; i < 8; i++) feed(1'b0, p[0]);
        cfg_write(8'h00, 4, 1'b1);
        for (int i = 0; i < 3; i++) feed(1'b0, p[0]);
        check("pre_reset_cnt", int'(match_count[7:0]), 5);
        #2 reset = 1'b1;
        #1;
        check("async_rst_cnt", int'(match_count), 0);
        check("async_rst_err", int'(cfg_err), 0);
        check("async_rst_det", int'(detector_out), 0);
        model_clear();
        step();
        reset = 1'b0;
        // Reset config is pattern 0, L=MAX_LEN: first pulse after 8 fresh zeros
        p = '0;
        for (int i = 0; i < 8; i++) feed(1'b0, p[i]);
        check("post_rst_pulses", int'(p), int'(8'b1000_0000));

        // Randomised traffic on all channels
        cfg_write(8'b0000_0010, 2, 1'b1);
        for (int i = 0; i < 600; i++) begin
            enable      = ($urandom_range(0, 7) != 0);
            in_valid    = 1'($urandom_range(0, 1));
            sequence_in = CH'($urandom);
            count_clr   = ($urandom_range(0, 29) == 0);
            cfg_we      = ($urandom_range(0, 19) == 0);
            if (cfg_we) begin
                cfg_pattern = MAX_LEN'($urandom);
                cfg_overlap = 1'($urandom);
                if ($urandom_range(0, 3) == 0)
                    cfg_len = LEN_W'($urandom_range(0, 10));
                else
                    cfg_len = LEN_W'($urandom_range(1, 3));
            end
            step();
        end
        cfg_we    = 1'b0;
        count_clr = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
